// File: rtl/bpm_packet_parser.sv
// BPM AXI-stream packet parser: validates 5-word packets (header, X, Y, S, CRC),
// publishes decoded fields on a one-cycle strobe and keeps saturating error statistics.
module bpm_packet_parser #(
    parameter logic [15:0] MAGIC     = 16'hA5BE,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          s_tdata,
    input  logic                 s_tlast,
    input  logic                 s_tvalid,
    input  logic                 clear_counters,
    output logic                 pkt_valid,
    output logic [8:0]           fofb_index,
    output logic [4:0]           cell_index,
    output logic                 fofb_enabled,
    output logic [31:0]          pos_x,
    output logic [31:0]          pos_y,
    output logic [29:0]          sum,
    output logic                 crc_fault,
    output logic                 adc_clip,
    output logic [CNT_WIDTH-1:0] good_count,
    output logic [CNT_WIDTH-1:0] bad_magic_count,
    output logic [CNT_WIDTH-1:0] short_count,
    output logic [CNT_WIDTH-1:0] long_count
);

    typedef enum logic [2:0] {HDR, WX, WY, WS, WCRC, DISCARD} state_t;

    state_t      state;
    logic [8:0]  stg_fofb_index;
    logic [4:0]  stg_cell_index;
    logic        stg_fofb_enabled;
    logic [31:0] stg_x;
    logic [31:0] stg_y;
    logic [31:0] stg_s;

    logic inc_good_c;
    logic inc_bad_magic_c;
    logic inc_short_c;
    logic inc_long_c;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_WIDTH'(1);
    endfunction

    // Per-word classification: at most one statistic bumps per malformed packet.
    always_comb begin
        inc_good_c      = 1'b0;
        inc_bad_magic_c = 1'b0;
        inc_short_c     = 1'b0;
        inc_long_c      = 1'b0;
        if (s_tvalid) begin
            case (state)
                HDR: begin
                    if (s_tlast)
                        inc_short_c = 1'b1;
                    else if (s_tdata[31:16] != MAGIC)
                        inc_bad_magic_c = 1'b1;
                end
                WX, WY, WS: inc_short_c = s_tlast;
                WCRC: begin
                    inc_good_c = s_tlast;
                    inc_long_c = ~s_tlast;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= HDR;
            pkt_valid        <= 1'b0;
            stg_fofb_index   <= '0;
            stg_cell_index   <= '0;
            stg_fofb_enabled <= 1'b0;
            stg_x            <= '0;
            stg_y            <= '0;
            stg_s            <= '0;
            fofb_index       <= '0;
            cell_index       <= '0;
            fofb_enabled     <= 1'b0;
            pos_x            <= '0;
            pos_y            <= '0;
            sum              <= '0;
            crc_fault        <= 1'b0;
            adc_clip         <= 1'b0;
        end else begin
            pkt_valid <= 1'b0;
            if (s_tvalid) begin
                case (state)
                    HDR: begin
                        if (!s_tlast) begin
                            if (s_tdata[31:16] == MAGIC) begin
                                stg_fofb_index   <= s_tdata[8:0];
                                stg_cell_index   <= s_tdata[14:10];
                                stg_fofb_enabled <= s_tdata[15];
                                state            <= WX;
                            end else begin
                                state <= DISCARD;
                            end
                        end
                    end
                    WX: begin
                        stg_x <= s_tdata;
                        state <= s_tlast ? HDR : WY;
                    end
                    WY: begin
                        stg_y <= s_tdata;
                        state <= s_tlast ? HDR : WS;
                    end
                    WS: begin
                        stg_s <= s_tdata;
                        state <= s_tlast ? HDR : WCRC;
                    end
                    WCRC: begin
                        if (s_tlast) begin
                            fofb_index   <= stg_fofb_index;
                            cell_index   <= stg_cell_index;
                            fofb_enabled <= stg_fofb_enabled;
                            pos_x        <= stg_x;
                            pos_y        <= stg_y;
                            sum          <= stg_s[29:0];
                            crc_fault    <= stg_s[31];
                            adc_clip     <= stg_s[30];
                            pkt_valid    <= 1'b1;
                            state        <= HDR;
                        end else begin
                            state <= DISCARD;
                        end
                    end
                    DISCARD: begin
                        if (s_tlast)
                            state <= HDR;
                    end
                    default: state <= HDR;
                endcase
            end
        end
    end

    // Saturating statistics; a clear wins over a same-cycle increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            good_count      <= '0;
            bad_magic_count <= '0;
            short_count     <= '0;
            long_count      <= '0;
        end else if (clear_counters) begin
            good_count      <= '0;
            bad_magic_count <= '0;
            short_count     <= '0;
            long_count      <= '0;
        end else begin
            if (inc_good_c)      good_count      <= sat_inc(good_count);
            if (inc_bad_magic_c) bad_magic_count <= sat_inc(bad_magic_count);
            if (inc_short_c)     short_count     <= sat_inc(short_count);
            if (inc_long_c)      long_count      <= sat_inc(long_count);
        end
    end

endmodule

// File: doc/bpm_packet_parser.md
BPM_PACKET_PARSER -- requirements
Module: bpm_packet_parser

Interface
REQ-001 SHALL have parameter MAGIC, default 16'hA5BE: required header bits [31:16].
REQ-002 SHALL have parameter CNT_WIDTH, default 16: width of each error and packet counter.
REQ-003 SHALL have one clock; reset is asynchronous and active-high.
REQ-004 clk  input  1  sole clock; all logic on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 s_tdata  input  32  BPM AXI stream data word.
REQ-007 s_tlast  input  1  last word of packet.
REQ-008 s_tvalid  input  1  word valid. No tready: every valid word is accepted.
REQ-009 clear_counters  input  1  synchronous clear of all counters.
REQ-010 pkt_valid  output  1  one-cycle strobe: a new good packet is on the field outputs.
REQ-011 fofb_index  output  9  header bits [8:0].
REQ-012 cell_index  output  5  header bits [14:10].
REQ-013 fofb_enabled  output  1  header bit 15.
REQ-014 pos_x, pos_y  output  32 each  Data X and Data Y words, in nm.
REQ-015 sum  output  30  Data S bits [29:0].
REQ-016 crc_fault, adc_clip  output  1 each  Data S bits 31 and 30.
REQ-017 good_count, bad_magic_count, short_count, long_count  output  CNT_WIDTH each  packet statistics.

Function
REQ-018 Packet format SHALL be 5 words: header, X, Y, S, CRC. tlast SHALL be on the CRC word only. The CRC word value SHALL be ignored.
REQ-019 FSM states SHALL be HDR, WX, WY, WS, WCRC, DISCARD. Reset state SHALL be HDR.
REQ-020 All transitions SHALL occur only on cycles with s_tvalid=1. s_tvalid=0 cycles SHALL hold the state; gaps between words are legal.
REQ-021 HDR, s_tlast=1: short_count++, stay in HDR.
REQ-022 HDR, s_tdata[31:16]!=MAGIC, s_tlast=0: bad_magic_count++, go to DISCARD.
REQ-023 HDR, magic OK, s_tlast=0: latch header fields into staging registers, go to WX.
REQ-024 WX/WY/WS, s_tlast=0: latch X/Y/S into staging registers, advance to the next state.
REQ-025 WX/WY/WS, s_tlast=1: short_count++, go to HDR, staging discarded.
REQ-026 WCRC, s_tlast=1: copy staging registers to the field outputs, pulse pkt_valid, good_count++, go to HDR.
REQ-027 WCRC, s_tlast=0: long_count++, go to DISCARD.
REQ-028 DISCARD: drop words until s_tlast=1, then go to HDR.
REQ-029 Field outputs SHALL change only on a good packet and SHALL hold their value otherwise.
REQ-030 Latency: pkt_valid and the updated fields SHALL appear on the first rising edge after the CRC-word edge, i.e. 1 cycle.
REQ-031 Back-to-back packets with no idle cycles SHALL parse at full rate with no lost words. Maximum pkt_valid rate is one strobe per 5 cycles.
REQ-032 Counters SHALL saturate at all-ones and never wrap.
REQ-033 clear_counters=1 SHALL zero all counters on the next edge. It SHALL take priority over a simultaneous increment and SHALL NOT affect the FSM or fields.
REQ-034 Each error SHALL increment exactly one counter once per malformed packet.

Reset
REQ-035 On rst assertion, immediately and regardless of clk: FSM to HDR, pkt_valid=0, all fields=0, all counters=0, staging registers=0.
REQ-036 rst mid-packet SHALL abandon the packet with no counter update. After release, parsing SHALL restart at the next word, treating it as a header.
REQ-037 The first clk edge after rst deassertion SHALL already accept s_tvalid.

Verification
REQ-038 Good packet: words A5BE_8C05, 0000_1000, FFFF_F000, 8000_0123, ADADFACE(tlast) -> one cycle later: pkt_valid=1, fofb_enabled=1, cell_index=3, fofb_index=5, pos_x=0x1000, pos_y=0xFFFFF000, crc_fault=1, adc_clip=0, sum=0x123, good_count=1.
REQ-039 Bad magic: header 1234_8001, then 4 words with tlast on the last -> bad_magic_count=1, no pkt_valid. A following good packet is parsed correctly.
REQ-040 Short and long packets: tlast on word 3 -> short_count=1. A 7-word packet with tlast on word 7 -> long_count=1. Neither produces pkt_valid. The next good packet gives good_count=1.
REQ-041 Throughput: 8 back-to-back good packets (fofb_index 0..7, tvalid continuously high, 40 cycles) -> 8 pkt_valid strobes spaced 5 cycles apart, indices 0..7 in order. Repeat with random tvalid gaps -> same results.
REQ-042 rst pulse during word 2 of a packet, then a good packet -> all counters 0 except good_count=1, and fields from the second packet.
REQ-043 Saturation and clear: with CNT_WIDTH=4, send 20 short packets -> short_count=15. Assert clear_counters in the same cycle as a good CRC word -> good_count=0, pkt_valid still pulses.
